// File: rtl/fifo_defines_pkg.sv
// Shared definitions for the SPI/FIFO datapath.
//   DATA_WIDTH         : serial word width in bits
//   BIT_COUNTER_WIDTH  : bits needed to count positions inside a word
//   RX_TIMEOUT_CYCLES  : default clk cycles allowed between sclk rises in a word
//   rx_state_t         : receive-side FSM state encoding
package fifo_defines_pkg;

    localparam int DATA_WIDTH        = 8;
    localparam int BIT_COUNTER_WIDTH = $clog2(DATA_WIDTH);
    localparam int RX_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STORE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/spi_deserializer_if.sv
// Signal bundle between the serial link / RX FIFO side and the deserializer.
//   sclk, mosi    : serial clock and data from the serializer
//   full, clr_err : RX FIFO full flag and sticky-error clear
//   write_en, write_data : FIFO write strobe and word
//   rx_busy, overflow, frame_err : status
// master = link/FIFO side, slave = deserializer.
interface spi_deserializer_if #(
    parameter int DATA_WIDTH = fifo_defines_pkg::DATA_WIDTH
);
    logic                  sclk;
    logic                  mosi;
    logic                  full;
    logic                  clr_err;
    logic                  write_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  rx_busy;
    logic                  overflow;
    logic                  frame_err;

    modport master (
        output sclk, mosi, full, clr_err,
        input  write_en, write_data, rx_busy, overflow, frame_err
    );

    modport slave (
        input  sclk, mosi, full, clr_err,
        output write_en, write_data, rx_busy, overflow, frame_err
    );
endinterface

// File: rtl/spi_rx_sync.sv
// Synchronizer and rising-edge detector for the serial inputs.
//   clk, rst  : system clock, async active-low reset
//   sclk, mosi: asynchronous serial pins
//   sclk_rise : one-cycle pulse per synchronized sclk rising edge
//   mosi_s    : synchronized mosi, aligned with sclk_rise
module spi_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic mosi,
    output logic sclk_rise,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;

    // Edge detect and mosi share one extra register stage so the data bit
    // presented with sclk_rise is the one sampled with that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            sclk_rise <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
            mosi_s    <= mosi_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/spi_deserializer.sv
// SPI receive deserializer: assembles MSB-first words from sclk/mosi and
// writes them into the RX FIFO, flagging overflow and frame timeouts.
//   clk, rst : system clock, async active-low reset
//   bus      : spi_deserializer_if.slave (serial inputs, FIFO write, status)
module spi_deserializer
    import fifo_defines_pkg::*;
#(
    parameter int DATA_WIDTH     = fifo_defines_pkg::DATA_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = fifo_defines_pkg::RX_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    spi_deserializer_if.slave  bus
);

    // Widen the bit counter if DATA_WIDTH is overridden beyond the package default.
    localparam int CNT_W = ((DATA_WIDTH > (1 << BIT_COUNTER_WIDTH)) ?
                            $clog2(DATA_WIDTH) : BIT_COUNTER_WIDTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'((DATA_WIDTH > 1) ? DATA_WIDTH - 2 : 0);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam rx_state_t        FIRST_NEXT = (DATA_WIDTH == 1) ? STORE : SHIFT;

    rx_state_t             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] last_data;
    logic [CNT_W-1:0]      bit_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic                  rx_busy_q;
    logic                  overflow_q;
    logic                  frame_err_q;
    logic                  sclk_rise;
    logic                  mosi_s;
    logic                  timeout_hit;
    logic                  store_write;

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (bus.sclk),
        .mosi      (bus.mosi),
        .sclk_rise (sclk_rise),
        .mosi_s    (mosi_s)
    );

    assign timeout_hit = (state == SHIFT) && !sclk_rise && (to_cnt == TO_MAX);
    // full is only looked at while in STORE, so the strobe is qualified here.
    assign store_write = (state == STORE) && !bus.full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            last_data   <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            rx_busy_q   <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (store_write) last_data <= shift_reg;
            // Set has priority over clear.
            overflow_q  <= ((state == STORE) && bus.full) | (overflow_q & ~bus.clr_err);
            frame_err_q <= timeout_hit | (frame_err_q & ~bus.clr_err);

            case (state)
                IDLE, STORE: begin
                    to_cnt <= '0;
                    if (sclk_rise) begin
                        shift_reg <= DATA_WIDTH'(mosi_s);
                        bit_cnt   <= BIT_LOAD;
                        state     <= FIRST_NEXT;
                        rx_busy_q <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        shift_reg <= DATA_WIDTH'({shift_reg, mosi_s});
                        to_cnt    <= '0;
                        if (bit_cnt == '0) state <= STORE;
                        else bit_cnt <= bit_cnt - 1'b1;
                    end else if (timeout_hit) begin
                        shift_reg <= '0;
                        to_cnt    <= '0;
                        state     <= IDLE;
                        rx_busy_q <= 1'b0;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.write_en   = store_write;
    assign bus.write_data = store_write ? shift_reg : last_data;
    assign bus.rx_busy    = rx_busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_deserializer.sv
// Self-checking bench for spi_deserializer: table of words with FIFO-full
// settings plus hand sequences for latency, timeout, reset and set/clear.
module tb_spi_deserializer;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int TO   = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_deserializer_if #(.DATA_WIDTH(DW)) bus ();

    spi_deserializer #(
        .DATA_WIDTH     (DW),
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];
    logic          prev_we = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        logic          full;
        logic          clr_after;
        logic          exp_ov;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected word.
    always @(negedge clk) begin
        if (rst && bus.write_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got %0h expected none", bus.write_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (bus.write_data !== e) begin
                    errors++;
                    $display("FAIL write_data: got %0h expected %0h", bus.write_data, e);
                end
            end
            if (prev_we) begin
                errors++;
                $display("FAIL double_write_en: got 2 consecutive expected 1");
            end
        end
        prev_we = rst && bus.write_en;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bus.mosi = w[DW-1-i];
            bus.sclk = 1'b0;
            tick(); tick();
            bus.sclk = 1'b1;
            tick(); tick();
        end
        bus.sclk = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.rx_busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_wait", {31'd0, bus.rx_busy}, 32'd0);
    endtask

    // Sends a word with the last bit handled by hand so the pin-to-strobe
    // latency can be measured; optionally pulses clr_err in the STORE cycle.
    task automatic send_word_timed(input logic [DW-1:0] w, input logic clr_store,
                                   output int lat, output logic busy_after);
        send_bits(w, DW - 1);
        bus.mosi = w[0];
        bus.sclk = 1'b0;
        tick(); tick();
        bus.sclk = 1'b1;
        lat = -1;
        busy_after = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 2) bus.sclk = 1'b0;
            if (clr_store) bus.clr_err = (k == 4);
            if (lat > 0 && k == lat + 1) busy_after = bus.rx_busy;
            if (lat < 0 && bus.write_en) lat = k;
        end
        bus.clr_err = 1'b0;
    endtask

    initial begin
        int lat;
        logic busy_after;

        vecs[0] = '{data: 8'h3C, full: 1'b0, clr_after: 1'b0, exp_ov: 1'b0};
        vecs[1] = '{data: 8'hC3, full: 1'b0, clr_after: 1'b0, exp_ov: 1'b0};
        vecs[2] = '{data: 8'hFF, full: 1'b1, clr_after: 1'b0, exp_ov: 1'b1};
        vecs[3] = '{data: 8'h01, full: 1'b0, clr_after: 1'b1, exp_ov: 1'b1};
        vecs[4] = '{data: 8'h96, full: 1'b0, clr_after: 1'b0, exp_ov: 1'b0};

        bus.sclk = 1'b0; bus.mosi = 1'b0; bus.full = 1'b0; bus.clr_err = 1'b0;
        tick(); tick();
        check("rst_write_en",  {31'd0, bus.write_en},  32'd0);
        check("rst_rx_busy",   {31'd0, bus.rx_busy},   32'd0);
        check("rst_overflow",  {31'd0, bus.overflow},  32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_data",      {24'd0, bus.write_data}, 32'd0);
        rst = 1'b1;
        tick(); tick();

        // Single word with latency and busy release.
        exp_q.push_back(8'hA5);
        send_word_timed(8'hA5, 1'b0, lat, busy_after);
        check("latency_cycles", lat, SYNC + 2);
        check("busy_after_write", {31'd0, busy_after}, 32'd0);
        check("hold_data", {24'd0, bus.write_data}, 32'hA5);
        wait_idle();

        // Back-to-back words without idling between them.
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        send_bits(8'h3C, DW);
        send_bits(8'hC3, DW);
        wait_idle();
        check("b2b_sb_empty", exp_q.size(), 0);
        check("b2b_no_ovf", {31'd0, bus.overflow}, 32'd0);
        check("b2b_no_ferr", {31'd0, bus.frame_err}, 32'd0);

        // Table of words with FIFO-full settings.
        for (int v = 0; v < 5; v++) begin
            bus.full = vecs[v].full;
            if (!vecs[v].full) exp_q.push_back(vecs[v].data);
            send_bits(vecs[v].data, DW);
            wait_idle();
            bus.full = 1'b0;
            tick();
            check($sformatf("vec%0d_sb_empty", v), exp_q.size(), 0);
            check($sformatf("vec%0d_overflow", v), {31'd0, bus.overflow}, {31'd0, vecs[v].exp_ov});
            check($sformatf("vec%0d_frame_err", v), {31'd0, bus.frame_err}, 32'd0);
            if (vecs[v].clr_after) begin
                bus.clr_err = 1'b1;
                tick();
                bus.clr_err = 1'b0;
                tick();
                check($sformatf("vec%0d_ovf_cleared", v), {31'd0, bus.overflow}, 32'd0);
            end
        end

        // Timeout after a partial word, boundary on both sides.
        send_bits(8'hB7, 5);
        repeat (60) tick();
        check("timeout_early", {31'd0, bus.frame_err}, 32'd0);
        repeat (10) tick();
        check("timeout_ferr", {31'd0, bus.frame_err}, 32'd1);
        check("timeout_idle", {31'd0, bus.rx_busy}, 32'd0);
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, DW);
        wait_idle();
        check("after_to_sb_empty", exp_q.size(), 0);
        check("ferr_sticky", {31'd0, bus.frame_err}, 32'd1);

        // Asynchronous reset in the middle of a word.
        send_bits(8'hE7, 3);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_busy",  {31'd0, bus.rx_busy},   32'd0);
        check("midrst_ferr",  {31'd0, bus.frame_err}, 32'd0);
        check("midrst_we",    {31'd0, bus.write_en},  32'd0);
        check("midrst_data",  {24'd0, bus.write_data}, 32'd0);
        tick(); tick();
        rst = 1'b1;
        tick(); tick();
        exp_q.push_back(8'h81);
        send_bits(8'h81, DW);
        wait_idle();
        check("post_rst_sb_empty", exp_q.size(), 0);

        // clr_err in the same cycle as an overflow set: set must win.
        bus.full = 1'b1;
        send_word_timed(8'h77, 1'b1, lat, busy_after);
        bus.full = 1'b0;
        tick();
        check("collision_no_write", lat, -1);
        check("collision_ovf", {31'd0, bus.overflow}, 32'd1);

        repeat (5) tick();
        check("final_sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
